// File: rtl/i2c_init_sequencer_pkg.sv
// Shared definitions for the I2C init sequencer: FSM encoding and table markers.
package i2c_init_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        FETCH         = 4'd1,
        ISSUE         = 4'd2,
        WAIT_ACCEPT   = 4'd3,
        WAIT_COMPLETE = 4'd4,
        CHECK         = 4'd5,
        DELAY         = 4'd6,
        DONE          = 4'd7,
        FAIL          = 4'd8
    } seq_state_t;

    localparam logic [7:0] END_MARKER   = 8'hFF;
    localparam logic [7:0] DELAY_MARKER = 8'hFE;

    function automatic logic state_is_active(input seq_state_t s);
        return !((s == IDLE) || (s == DONE) || (s == FAIL));
    endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Request/response bundle between the init sequencer and an I2C write master.
interface i2c_init_sequencer_if;
    logic       i2cStartWrite;
    logic [6:0] i2cAddress;
    logic [7:0] i2cReg;
    logic [7:0] i2cData;
    logic       i2cBusy;
    logic       i2cAckError;

    modport master (
        output i2cStartWrite, i2cAddress, i2cReg, i2cData,
        input  i2cBusy, i2cAckError
    );

    modport slave (
        input  i2cStartWrite, i2cAddress, i2cReg, i2cData,
        output i2cBusy, i2cAckError
    );
endinterface

// File: rtl/i2c_init_sequencer_delay_timer.sv
// Down-counter for delay table entries: load a cycle count, count down, flag zero.
module i2c_delay_timer #(
    parameter int WIDTH = 22
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_count,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; counting saturates at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a register-init table and issues one I2C write per entry, with retries and delays.
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h21,
    parameter int         NR_OF_ENTRIES  = 32,
    parameter int         MAX_RETRIES    = 3,
    parameter int         DELAY_UNIT     = 12000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    output logic [$clog2(NR_OF_ENTRIES)-1:0] tableIndex,
    input  logic [7:0]                       tableReg,
    input  logic [7:0]                       tableData,
    i2c_init_sequencer_if.master             i2c,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(NR_OF_ENTRIES)-1:0] failIndex
);

    localparam int IW = $clog2(NR_OF_ENTRIES);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int DW = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NR_OF_ENTRIES - 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_fail_idx;
    logic [RW-1:0] r_retry;
    logic          r_start_write;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [7:0]    r_reg;
    logic [7:0]    r_data;
    logic          w_clear;
    logic          w_inc_idx;
    logic          w_retry_inc;
    logic          w_retry_clr;
    logic          w_fail;
    logic          w_load;
    logic          w_sw;
    logic          w_zero;
    logic          w_last;
    logic          w_counting;
    logic [DW-1:0] w_delay_cycles;
    logic [DW-1:0] w_load_value;

    assign w_last         = (r_idx == LAST_IDX);
    assign w_counting     = (r_state == DELAY);
    assign w_delay_cycles = DW'(tableData) * DW'(DELAY_UNIT);
    // DELAY itself spends one cycle on the zero count, so load one less.
    assign w_load_value   = (w_delay_cycles == '0) ? '0 : (w_delay_cycles - DW'(1));

    i2c_delay_timer #(.WIDTH(DW)) u_delay_timer (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_count (w_counting),
        .i_value (w_load_value),
        .o_zero  (w_zero)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_inc_idx   = 1'b0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_fail      = 1'b0;
        w_load      = 1'b0;
        w_sw        = 1'b0;
        case (r_state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    w_next  = FETCH;
                    w_clear = 1'b1;
                end else begin
                    w_next = r_state;
                end
            end
            FETCH: begin
                if (tableReg == END_MARKER) begin
                    w_next = DONE;
                end else if (tableReg == DELAY_MARKER) begin
                    w_next = DELAY;
                    w_load = 1'b1;
                end else begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!i2c.i2cBusy) begin
                    w_next = WAIT_ACCEPT;
                    w_sw   = 1'b1;
                end else begin
                    w_next = ISSUE;
                end
            end
            WAIT_ACCEPT: begin
                if (i2c.i2cBusy) begin
                    w_next = WAIT_COMPLETE;
                end else begin
                    w_next = WAIT_ACCEPT;
                end
            end
            WAIT_COMPLETE: begin
                if (!i2c.i2cBusy) begin
                    w_next = CHECK;
                end else begin
                    w_next = WAIT_COMPLETE;
                end
            end
            CHECK: begin
                if (!i2c.i2cAckError) begin
                    w_retry_clr = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_next    = FETCH;
                        w_inc_idx = 1'b1;
                    end
                end else if (r_retry < RW'(MAX_RETRIES)) begin
                    w_next      = ISSUE;
                    w_retry_inc = 1'b1;
                end else begin
                    w_next = FAIL;
                    w_fail = 1'b1;
                end
            end
            DELAY: begin
                if (w_zero) begin
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_next    = FETCH;
                        w_inc_idx = 1'b1;
                    end
                end else begin
                    w_next = DELAY;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Registered outputs, table index, retry count and latched entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start_write <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_idx         <= '0;
            r_fail_idx    <= '0;
            r_retry       <= '0;
            r_reg         <= 8'h00;
            r_data        <= 8'h00;
        end else begin
            r_start_write <= w_sw;
            r_busy        <= state_is_active(w_next);
            r_done        <= (w_next == DONE);
            r_error       <= (w_next == FAIL);
            if (w_clear) begin
                r_idx <= '0;
            end else if (w_inc_idx) begin
                r_idx <= r_idx + IW'(1);
            end
            if (w_clear || w_retry_clr) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RW'(1);
            end
            if (w_fail) begin
                r_fail_idx <= r_idx;
            end
            if (r_state == FETCH) begin
                r_reg  <= tableReg;
                r_data <= tableData;
            end
        end
    end

    assign tableIndex        = r_idx;
    assign failIndex         = r_fail_idx;
    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;
    assign i2c.i2cStartWrite = r_start_write;
    assign i2c.i2cAddress    = DEVICE_ADDRESS;
    assign i2c.i2cReg        = r_reg;
    assign i2c.i2cData       = r_data;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench: a master model acks/nacks writes; expected writes are queued per test.
module tb_i2c_init_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] tableIndex;
    logic [7:0] tableReg;
    logic [7:0] tableData;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] failIndex;

    logic [7:0]  tbl_reg  [4];
    logic [7:0]  tbl_data [4];
    logic [15:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;
    int          cyc     = 0;
    int          nack_entry = -1;
    int          nack_left  = 0;
    int          m_cnt = 0;
    logic        m_ack = 1'b0;
    logic        prev_sw = 1'b0;
    logic [1:0]  prev_idx = 2'd0;
    int          idx_t [4];
    int          base;

    i2c_init_sequencer_if bus ();

    assign tableReg  = tbl_reg[tableIndex];
    assign tableData = tbl_data[tableIndex];

    i2c_init_sequencer #(
        .DEVICE_ADDRESS (7'h21),
        .NR_OF_ENTRIES  (4),
        .MAX_RETRIES    (3),
        .DELAY_UNIT     (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .tableIndex (tableIndex),
        .tableReg   (tableReg),
        .tableData  (tableData),
        .i2c        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .failIndex  (failIndex)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [7:0] r, input logic [7:0] d);
        tbl_reg[i]  = r;
        tbl_data[i] = d;
    endtask

    task automatic push_exp(input int i);
        exp_q.push_back({tbl_reg[i], tbl_data[i]});
    endtask

    task automatic run_seq(input int budget);
        int n;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(done || error) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        check_val("seq_end", 32'(done || error), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Master model: accepts a write, stays busy 4 cycles, then reports ack/nack.
    initial begin
        bus.i2cBusy     = 1'b0;
        bus.i2cAckError = 1'b0;
        forever begin
            @(negedge clock);
            if (tableIndex != prev_idx) idx_t[tableIndex] = cyc;
            prev_idx = tableIndex;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.i2cBusy     = 1'b0;
                    bus.i2cAckError = m_ack;
                end
            end
            if (bus.i2cStartWrite === 1'b1) begin
                logic [15:0] e;
                pulses++;
                check_val("sw_spacing", 32'(prev_sw), 32'd0);
                check_val("addr", 32'(bus.i2cAddress), 32'h21);
                check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("wr_reg", 32'(bus.i2cReg), 32'(e[15:8]));
                    check_val("wr_data", 32'(bus.i2cData), 32'(e[7:0]));
                end
                m_ack = (int'(tableIndex) == nack_entry) && (nack_left > 0);
                if (m_ack) nack_left--;
                bus.i2cBusy = 1'b1;
                m_cnt = 4;
            end
            prev_sw = bus.i2cStartWrite;
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) set_entry(i, 8'hFF, 8'h00);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_done",  32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_index", 32'(tableIndex), 32'd0);
        check_val("rst_fidx",  32'(failIndex), 32'd0);
        check_val("rst_sw",    32'(bus.i2cStartWrite), 32'd0);
        check_val("rst_reg",   32'(bus.i2cReg), 32'd0);
        check_val("rst_data",  32'(bus.i2cData), 32'd0);
        reset = 1'b0;

        // Three acked writes, then end marker.
        set_entry(0, 8'h10, 8'hA1); set_entry(1, 8'h11, 8'hB2);
        set_entry(2, 8'h12, 8'hC3); set_entry(3, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) push_exp(i);
        base = pulses;
        run_seq(2000);
        check_val("a_pulses", 32'(pulses - base), 32'd3);
        check_val("a_done",   32'(done), 32'd1);
        check_val("a_error",  32'(error), 32'd0);
        check_val("a_busy",   32'(busy), 32'd0);
        check_val("a_index",  32'(tableIndex), 32'd3);
        check_val("a_sb_empty", 32'(exp_q.size()), 32'd0);

        // Entry 1 nacked twice, acked on the third attempt.
        set_entry(0, 8'h20, 8'h01); set_entry(1, 8'h21, 8'h02);
        set_entry(2, 8'hFF, 8'h00); set_entry(3, 8'hFF, 8'h00);
        push_exp(0); push_exp(1); push_exp(1); push_exp(1);
        nack_entry = 1; nack_left = 2;
        base = pulses;
        run_seq(2000);
        check_val("b_pulses", 32'(pulses - base), 32'd4);
        check_val("b_done",   32'(done), 32'd1);
        check_val("b_error",  32'(error), 32'd0);

        // Entry 2 never acked: 1 + MAX_RETRIES attempts then failure.
        set_entry(0, 8'h30, 8'h11); set_entry(1, 8'h31, 8'h22);
        set_entry(2, 8'h32, 8'h33); set_entry(3, 8'hFF, 8'h00);
        push_exp(0); push_exp(1);
        for (int i = 0; i < 4; i++) push_exp(2);
        nack_entry = 2; nack_left = 1000;
        base = pulses;
        run_seq(2000);
        idle_cycles(30);
        check_val("c_pulses", 32'(pulses - base), 32'd6);
        check_val("c_error",  32'(error), 32'd1);
        check_val("c_done",   32'(done), 32'd0);
        check_val("c_busy",   32'(busy), 32'd0);
        check_val("c_fidx",   32'(failIndex), 32'd2);
        nack_entry = -1; nack_left = 0;

        // Delay entry of 2 units (20 cycles) plus one FETCH between index advances.
        set_entry(0, 8'h40, 8'h11); set_entry(1, 8'hFE, 8'h02);
        set_entry(2, 8'h41, 8'h22); set_entry(3, 8'hFF, 8'h00);
        push_exp(0); push_exp(2);
        base = pulses;
        run_seq(2000);
        check_val("d_pulses", 32'(pulses - base), 32'd2);
        check_val("d_gap",    32'(idx_t[2] - idx_t[1]), 32'd21);
        check_val("d_done",   32'(done), 32'd1);

        // Reset while the master is mid-write, then restart from entry 0.
        set_entry(0, 8'h50, 8'h5A); set_entry(1, 8'h51, 8'h5B);
        set_entry(2, 8'hFF, 8'h00); set_entry(3, 8'hFF, 8'h00);
        push_exp(0);
        base = pulses;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int n = 0; (n < 200) && (bus.i2cBusy !== 1'b1); n++) @(negedge clock);
        check_val("e_master_busy", 32'(bus.i2cBusy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("e_busy_after_rst", 32'(busy), 32'd0);
        check_val("e_index_after_rst", 32'(tableIndex), 32'd0);
        reset = 1'b0;
        idle_cycles(20);
        check_val("e_no_pulse", 32'(pulses - base), 32'd1);
        check_val("e_idle_busy", 32'(busy), 32'd0);
        push_exp(0); push_exp(1);
        run_seq(2000);
        check_val("e_pulses", 32'(pulses - base), 32'd3);
        check_val("e_done",   32'(done), 32'd1);
        check_val("e_index",  32'(tableIndex), 32'd2);

        // Full table with no end marker: stops on the last entry.
        set_entry(0, 8'h60, 8'h01); set_entry(1, 8'h61, 8'h02);
        set_entry(2, 8'h62, 8'h03); set_entry(3, 8'h63, 8'h04);
        for (int i = 0; i < 4; i++) push_exp(i);
        base = pulses;
        run_seq(2000);
        idle_cycles(10);
        check_val("f_pulses", 32'(pulses - base), 32'd4);
        check_val("f_done",   32'(done), 32'd1);
        check_val("f_busy",   32'(busy), 32'd0);
        check_val("f_index",  32'(tableIndex), 32'd3);
        check_val("f_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
